// File: rtl/servo_slew_if.sv
// Target handshake and position/status bundle between the arm sequencer and the slew stage.
interface servo_slew_if;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_pos;
  logic [7:0] position;
  logic       busy;
  logic       done;

  // Sequencer side: offers targets, watches motion status.
  modport master (
    output tgt_valid,
    output tgt_pos,
    input  tgt_ready,
    input  position,
    input  busy,
    input  done
  );

  // Slew stage side.
  modport slave (
    input  tgt_valid,
    input  tgt_pos,
    output tgt_ready,
    output position,
    output busy,
    output done
  );
endinterface

// File: rtl/servo_slew.sv
// Rate-limited position profiler: clamps accepted targets, steps the commanded
// position by at most STEP per tick, then settles and pulses done.
module servo_slew #(
  parameter int unsigned TICK_CYCLES  = 100000,
  parameter int unsigned STEP         = 1,
  parameter int unsigned SETTLE_TICKS = 10,
  parameter int unsigned POS_MIN      = 0,
  parameter int unsigned POS_MAX      = 255,
  parameter int unsigned HOME         = 128
) (
  input logic         clk,
  input logic         rst,
  servo_slew_if.slave bus
);

  localparam int unsigned TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned SET_W       = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_TICKS == 0) ? 0 : SETTLE_TICKS - 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_LAST);
  localparam logic [7:0] MIN8  = 8'(POS_MIN);
  localparam logic [7:0] MAX8  = 8'(POS_MAX);
  localparam logic [7:0] HOME8 = 8'(HOME);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SETTLE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        pos_q, pos_d;
  logic [7:0]        tgt_q, tgt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              done_q, done_d;
  logic              ready_q;

  logic       accept;
  logic [7:0] tgt_clamp;
  logic [7:0] aim;
  logic [8:0] diff9;
  logic [8:0] mag9;
  logic       arrive;
  logic [7:0] step_pos;
  logic       tick_wrap;

  // Handshake, clamp and the one-tick step toward the effective target.
  always_comb begin
    accept    = bus.tgt_valid & ready_q;
    tgt_clamp = (bus.tgt_pos < MIN8) ? MIN8 :
                (bus.tgt_pos > MAX8) ? MAX8 : bus.tgt_pos;
    aim       = accept ? tgt_clamp : tgt_q;
    diff9     = {1'b0, aim} - {1'b0, pos_q};
    mag9      = diff9[8] ? (9'd0 - diff9) : diff9;
    arrive    = (mag9 <= STEP9);
    step_pos  = arrive ? aim : (diff9[8] ? pos_q - STEP8 : pos_q + STEP8);
    tick_wrap = (tick_q == TICK_LAST);
  end

  // Next-state logic: move cadence, settle timing, retarget and abort handling.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tgt_d    = tgt_q;
    tick_d   = tick_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    if (accept) tgt_d = tgt_clamp;
    case (state_q)
      S_IDLE, S_SETTLE: begin
        if (accept) begin
          tick_d   = '0;
          settle_d = '0;
          state_d  = (tgt_clamp == pos_q) ? S_SETTLE : S_MOVE;
        end else if (state_q == S_SETTLE) begin
          if (SETTLE_TICKS == 0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap) begin
              if (settle_q == SET_LAST) begin
                done_d   = 1'b1;
                state_d  = S_IDLE;
                settle_d = '0;
              end else begin
                settle_d = settle_q + SET_W'(1);
              end
            end
          end
        end
      end
      S_MOVE: begin
        // Retargets keep the running cadence; only arrival clears it.
        tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
        if (accept && (tgt_clamp == pos_q)) begin
          state_d  = S_SETTLE;
          tick_d   = '0;
          settle_d = '0;
        end else if (tick_wrap) begin
          pos_d = step_pos;
          if (arrive) begin
            state_d  = S_SETTLE;
            tick_d   = '0;
            settle_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pos_q    <= HOME8;
      tgt_q    <= HOME8;
      tick_q   <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      ready_q  <= 1'b1;
    end
  end

  assign bus.position  = pos_q;
  assign bus.tgt_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_servo_slew.sv
// Bench for servo_slew: table of single moves plus hand-written retarget,
// settle-abort and reset sequences, checked through an event scoreboard.
module tb_servo_slew;

  logic clk;
  logic rst;
  int   cyc = 0;

  servo_slew_if bus_if ();

  servo_slew #(
    .TICK_CYCLES (4),
    .STEP        (2),
    .SETTLE_TICKS(2),
    .POS_MIN     (10),
    .POS_MAX     (200),
    .HOME        (128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge count; an event seen at a negedge belongs to edge number cyc.
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_POS, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       val;
    int       cyc;
  } ev_t;
  typedef struct {
    logic [7:0] tgt;
    int         exp_final;
  } vec_t;

  ev_t  q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_pos;
  bit   mon_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_event(input ev_kind_e k, input int v);
    ev_t e;
    string kn;
    kn = (k == EV_POS) ? "position" : "done";
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got value %0d at cycle %0d, expected no event", kn, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        errors++;
        $display("FAIL event_%s: got value %0d at cycle %0d, expected %s %0d at cycle %0d",
                 kn, v, cyc, (e.kind == EV_POS) ? "position" : "done", e.val, e.cyc);
      end
    end
    if (k == EV_POS) begin
      checks++;
      if (v < 10 || v > 200) begin
        errors++;
        $display("FAIL pos_range: got %0d expected within 10..200", v);
      end
    end
  endtask

  // Advance to the next negedge and feed any observed events to the scoreboard.
  task automatic step_cycle();
    @(negedge clk);
    if (!mon_en) begin
      last_pos = bus_if.position;
    end else begin
      if (bus_if.position !== last_pos) begin
        check_event(EV_POS, int'(bus_if.position));
        last_pos = bus_if.position;
      end
      if (bus_if.done === 1'b1) check_event(EV_DONE, 0);
    end
  endtask

  task automatic accept(input logic [7:0] p, output int acc);
    bus_if.tgt_valid = 1'b1;
    bus_if.tgt_pos   = p;
    acc = cyc + 1;
    step_cycle();
    bus_if.tgt_valid = 1'b0;
  endtask

  // Expected positions per tick toward 'to', then done two ticks after arrival.
  task automatic plan_move(input int from, input int to, input int first_tick,
                           input int settle_start, input bit with_done);
    int p, t, last;
    p = from;
    t = first_tick;
    last = settle_start;
    while (p != to) begin
      if ((to - p) <= 2 && (p - to) <= 2) p = to;
      else if (to > p) p = p + 2;
      else p = p - 2;
      q.push_back('{EV_POS, p, t});
      last = t;
      t = t + 4;
    end
    if (with_done) q.push_back('{EV_DONE, 0, last + 8});
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      step_cycle();
      n++;
    end
    check({name, "_pending_events"}, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    mon_en = 0;
    q.delete();
    repeat (n) step_cycle();
    rst = 1'b1;
    step_cycle();
    last_pos = bus_if.position;
    mon_en = 1;
  endtask

  initial begin
    int a, b, c, d;
    rst = 1'b0;
    bus_if.tgt_valid = 1'b0;
    bus_if.tgt_pos   = 8'd0;

    vecs[0] = '{8'd134, 134};
    vecs[1] = '{8'd131, 131};
    vecs[2] = '{8'd5,   10};
    vecs[3] = '{8'd250, 200};
    vecs[4] = '{8'd128, 128};

    // Reset values held over three cycles, ready only after release.
    repeat (3) begin
      step_cycle();
      check("reset_ready", int'(bus_if.tgt_ready), 0);
    end
    check("reset_position", int'(bus_if.position), 128);
    check("reset_busy", int'(bus_if.busy), 0);
    check("reset_done", int'(bus_if.done), 0);
    rst = 1'b1;
    step_cycle();
    check("ready_after_release", int'(bus_if.tgt_ready), 1);
    check("position_after_release", int'(bus_if.position), 128);
    last_pos = bus_if.position;
    mon_en = 1;

    // Single moves from HOME: basic, odd remainder, clamps, zero-distance.
    for (int i = 0; i < 5; i++) begin
      do_reset(2);
      accept(vecs[i].tgt, a);
      check("busy_after_accept", int'(bus_if.busy), 1);
      plan_move(128, vecs[i].exp_final, a + 4, a, 1);
      drain(400, "vector");
      check("busy_after_done", int'(bus_if.busy), 0);
      check("final_position", int'(bus_if.position), vecs[i].exp_final);
      repeat (12) step_cycle();
    end

    // Retarget mid-move: reversal lands on the existing tick cadence.
    do_reset(2);
    accept(8'd140, a);
    q.push_back('{EV_POS, 130, a + 4});
    q.push_back('{EV_POS, 132, a + 8});
    drain(40, "retarget_head");
    accept(8'd120, b);
    plan_move(132, 120, a + 12, 0, 1);
    drain(200, "retarget_tail");
    check("retarget_busy_end", int'(bus_if.busy), 0);
    repeat (16) step_cycle();

    // Settle restart by same target, then abort by a new target.
    do_reset(2);
    accept(8'd134, a);
    plan_move(128, 134, a + 4, a, 0);
    drain(40, "abort_move");
    repeat (2) step_cycle();
    accept(8'd134, b);
    check("restart_busy", int'(bus_if.busy), 1);
    q.push_back('{EV_DONE, 0, b + 8});
    drain(40, "settle_restart");
    check("restart_busy_end", int'(bus_if.busy), 0);
    repeat (4) step_cycle();
    accept(8'd134, c);
    repeat (3) step_cycle();
    accept(8'd136, d);
    plan_move(134, 136, d + 4, d, 1);
    drain(40, "settle_abort");
    check("abort_position", int'(bus_if.position), 136);
    repeat (16) step_cycle();

    // Reset mid-move: snap to HOME, idle, no done afterwards.
    do_reset(2);
    accept(8'd150, a);
    q.push_back('{EV_POS, 130, a + 4});
    q.push_back('{EV_POS, 132, a + 8});
    drain(40, "midreset_head");
    rst = 1'b0;
    mon_en = 0;
    q.delete();
    step_cycle();
    check("midreset_position", int'(bus_if.position), 128);
    check("midreset_busy", int'(bus_if.busy), 0);
    check("midreset_done", int'(bus_if.done), 0);
    rst = 1'b1;
    step_cycle();
    last_pos = bus_if.position;
    mon_en = 1;
    repeat (24) step_cycle();
    check("midreset_hold", int'(bus_if.position), 128);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_slew.md
Name: servo_slew

Overview:
- Motion-profiling stage that sits directly upstream of the servo PWM generator and drives its 8-bit position input.
- Accepts target positions over a valid/ready handshake and clamps each one to a safe range.
- Moves the commanded position toward the target by at most STEP counts per tick, so joints never jump.
- After arrival it holds for a settle interval, then pulses done for the arm sequencer.

Parameters:
- TICK_CYCLES, 100000: clk cycles per slew tick (2 ms at 50 MHz); must be >= 1.
- STEP, 1: maximum position change per tick, range 1..255.
- SETTLE_TICKS, 10: ticks to hold at the target before done; 0 is legal.
- POS_MIN, 0: lowest permitted position.
- POS_MAX, 255: highest permitted position; must be >= POS_MIN.
- HOME, 128: position after reset; must lie within POS_MIN..POS_MAX.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-low; 0 resets on the clk edge.
- tgt_valid, input, 1: target offered.
- tgt_ready, output, 1: block can accept a target.
- tgt_pos, input, 8: requested position.
- position, output, 8: commanded position, wired to the servo position input.
- busy, output, 1: high when state != IDLE.
- done, output, 1: one-cycle pulse when a move completes settling.

Behaviour:
- Reset, sampled while rst=0 at a clk edge:
  - position=HOME, target register=HOME, state=IDLE.
  - tick counter=0, settle counter=0.
  - done=0, busy=0, tgt_ready=0.
- After reset, tgt_ready=1 on every cycle; a new target is accepted in any state.
- Acceptance occurs on a clk edge where tgt_valid=1 and tgt_ready=1.
  - The stored target is clamp(tgt_pos, POS_MIN, POS_MAX).
  - A later acceptance overrides an earlier one (retarget).
- All registered outputs update on the clk edge. position is a register, so there is no combinational path from tgt_pos.
- States:
  - IDLE: position holds.
    - Accept with clamped target != position: go to MOVE and clear the tick counter.
    - Accept with clamped target == position: go to SETTLE and clear both counters.
  - MOVE: the tick counter counts 0..TICK_CYCLES-1 and wraps. Each wrap is one tick.
    - On a tick with d = |target - position|: if d <= STEP, position=target and go to SETTLE with counters cleared; otherwise position moves STEP toward target.
    - Use 9-bit difference arithmetic so there is no 8-bit wrap-around. position never leaves POS_MIN..POS_MAX.
    - Accept during MOVE: the target is replaced and the tick counter is not cleared (cadence keeps going).
      - If the new target == position, go to SETTLE with counters cleared.
      - A direction reversal takes effect on the next tick.
  - SETTLE: position holds and ticks are counted.
    - When the settle count reaches SETTLE_TICKS, assert done for exactly 1 cycle and go to IDLE.
    - If SETTLE_TICKS=0, SETTLE lasts 1 cycle, then done.
    - Accept during SETTLE: abort the settle, with no done. Go to MOVE (tick counter cleared), or restart SETTLE if the target == position.
- Simultaneous events:
  - Acceptance on the same edge as the final settle tick: the acceptance wins and no done pulse is produced.
  - Acceptance on the same edge as a MOVE tick: the step uses the new target.
- rst=0 mid-move: position snaps to HOME on that edge, done is suppressed, and the move is lost.
- busy is combinational from the state register: 1 in MOVE and SETTLE.
- Move time from acceptance to the first step is TICK_CYCLES cycles.

Test Plan:
- Bench parameters for all scenarios: TICK_CYCLES=4, STEP=2, SETTLE_TICKS=2, POS_MIN=10, POS_MAX=200, HOME=128.
- Reset: hold rst=0 for 3 cycles, then release -> position=128, busy=0, done=0; tgt_ready=0 during reset and 1 from the first cycle after release.
- Basic move: accept 134 -> position 130, 132, 134 at 4-cycle spacing. busy=1 from the cycle after acceptance. done pulses exactly once, 8 cycles after reaching 134, then busy=0.
- Odd remainder and clamp:
  - Accept 131 -> 130, then 131 (last step 1).
  - Accept 5 -> target clamps to 10 and position descends to 10, never below.
  - Accept 250 -> target clamps to 200.
- Retarget mid-move: accept 140, then at position 132 accept 120 -> the next tick gives 130. Motion continues down to 120 with one done only.
- Settle abort: during SETTLE at 134 accept 134 -> settle restarts and done comes 2 ticks later. Accept 136 in SETTLE -> no done until after 136 settles.
- Reset mid-move: assert rst=0 while at 132 heading to 150 -> position=128 and busy=0 on that edge, with no done pulse.
